// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the MEM-stage request signals, the data-cache port and the
//   stall/result outputs of the MEM-stage memory sequencer.
//   master : the sequencer (consumes the pipeline request, drives the cache).
//   slave  : the surroundings (pipeline register + data cache).
//   Signals:
//     valid, opcode[3:0], mem_read, mem_write, address[15:0],
//     store_data[15:0], stage_load            pipeline -> sequencer
//     dmem_address[15:0], dmem_read, dmem_write,
//     dmem_byte_enable[1:0], dmem_wdata[15:0]  sequencer -> cache
//     dmem_rdata[15:0], dmem_resp              cache -> sequencer
//     mem_result[15:0], stall                  sequencer -> pipeline
interface mem_access_ctrl_if;
  logic        valid;
  logic [3:0]  opcode;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] address;
  logic [15:0] store_data;
  logic        stage_load;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] mem_result;
  logic        stall;

  modport master (
    input  valid, opcode, mem_read, mem_write, address, store_data, stage_load,
    input  dmem_rdata, dmem_resp,
    output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    output mem_result, stall
  );

  modport slave (
    output valid, opcode, mem_read, mem_write, address, store_data, stage_load,
    output dmem_rdata, dmem_resp,
    input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    input  mem_result, stall
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage memory sequencer for the pipelined LC-3b datapath. Issues the
//   data-cache access(es) for the MEM-stage instruction, runs the two-access
//   LDI/STI sequences, handles byte lanes for LDB/STB and stalls IF..MEM until
//   the access completes.
//   Ports:
//     clk   : sole clock, rising edge
//     reset : synchronous, active-high, returns the sequencer to IDLE
//     bus   : mem_access_ctrl_if.master (pipeline request, cache port,
//             mem_result and stall)
module mem_access_ctrl (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.master bus
);

  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_STB = 4'h3;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;

  typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2, COMPLETE} state_e;
  typedef enum logic [2:0] {K_WREAD, K_BREAD, K_WWRITE, K_BWRITE, K_LDI, K_STI} kind_e;

  state_e      state_q;
  kind_e       kind_q;
  kind_e       kind_d;
  logic        byte_hi_q;
  logic        gap_q;
  logic [15:0] dmem_address_q;
  logic        dmem_read_q;
  logic        dmem_write_q;
  logic [1:0]  dmem_be_q;
  logic [15:0] dmem_wdata_q;
  logic [15:0] mem_result_q;
  logic        req_s;
  logic        stall_s;

  // Zero-extended byte lane selected by the low address bit.
  function automatic logic [15:0] byte_extract(input logic [15:0] data, input logic hi);
    return {8'h00, (hi ? data[15:8] : data[7:0])};
  endfunction

  assign req_s = bus.valid & (bus.mem_read | bus.mem_write);

  // Access kind from the opcode; unknown opcodes with a request act as word reads.
  always_comb begin
    kind_d = K_WREAD;
    case (bus.opcode)
      OP_LDB:  kind_d = K_BREAD;
      OP_STR:  kind_d = K_WWRITE;
      OP_STB:  kind_d = K_BWRITE;
      OP_LDI:  kind_d = K_LDI;
      OP_STI:  kind_d = K_STI;
      default: kind_d = K_WREAD;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the same cycle the request appears.
  always_comb begin
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = req_s & (state_q != COMPLETE);
    end
  end

  // Sequencer FSM with registered cache strobes, lanes, data and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      kind_q         <= K_WREAD;
      byte_hi_q      <= 1'b0;
      gap_q          <= 1'b0;
      dmem_address_q <= 16'h0000;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_be_q      <= 2'b00;
      dmem_wdata_q   <= 16'h0000;
      mem_result_q   <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            kind_q         <= kind_d;
            byte_hi_q      <= bus.address[0];
            dmem_address_q <= bus.address & 16'hFFFE;
            dmem_read_q    <= (kind_d != K_WWRITE) && (kind_d != K_BWRITE);
            dmem_write_q   <= (kind_d == K_WWRITE) || (kind_d == K_BWRITE);
            // STI keeps store_data here until its second (write) access.
            if (kind_d == K_BWRITE) begin
              dmem_be_q    <= bus.address[0] ? 2'b10 : 2'b01;
              dmem_wdata_q <= {bus.store_data[7:0], bus.store_data[7:0]};
            end else begin
              dmem_be_q    <= 2'b11;
              dmem_wdata_q <= bus.store_data;
            end
            state_q <= ACCESS1;
          end
        end
        ACCESS1: begin
          if (bus.dmem_resp) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            if ((kind_q == K_LDI) || (kind_q == K_STI)) begin
              dmem_address_q <= bus.dmem_rdata & 16'hFFFE;
              gap_q          <= 1'b1;
              state_q        <= ACCESS2;
            end else begin
              if (kind_q == K_BREAD) begin
                mem_result_q <= byte_extract(bus.dmem_rdata, byte_hi_q);
              end else if (kind_q == K_WREAD) begin
                mem_result_q <= bus.dmem_rdata;
              end
              state_q <= COMPLETE;
            end
          end
        end
        ACCESS2: begin
          // gap_q marks the mandatory strobe-low cycle between the two accesses.
          if (gap_q) begin
            gap_q        <= 1'b0;
            dmem_read_q  <= (kind_q == K_LDI);
            dmem_write_q <= (kind_q == K_STI);
            dmem_be_q    <= 2'b11;
          end else if (bus.dmem_resp) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            if (kind_q == K_LDI) begin
              mem_result_q <= bus.dmem_rdata;
            end
            state_q <= COMPLETE;
          end
        end
        COMPLETE: begin
          // Wait for the pipeline to take this instruction before accepting another.
          if (bus.stage_load) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.dmem_address     = dmem_address_q;
  assign bus.dmem_read        = dmem_read_q;
  assign bus.dmem_write       = dmem_write_q;
  assign bus.dmem_byte_enable = dmem_be_q;
  assign bus.dmem_wdata       = dmem_wdata_q;
  assign bus.mem_result       = mem_result_q;
  assign bus.stall            = stall_s;

endmodule
